// File: rtl/dma_desc_queue.sv
// ---------------------------------------------------------------------------
// dma_desc_queue
//
// Descriptor FIFO and launch sequencer in front of the DMA controller. The
// host pushes transfer descriptors. Each one is popped in order and checked
// for shape. Good descriptors are copied into the DMA config registers and
// launched with a single-cycle dma_start. The block then waits for dma_done.
// Every descriptor, good or bad, produces exactly one completion record.
//
// Parameters
//   DEPTH           FIFO entries. Must be a power of two and at least 2.
//   TIMEOUT_CYCLES  RUN-state watchdog limit. It is only used when the
//                   DMA_DESC_TIMEOUT_EN macro is defined.
//
// Build option
//   DMA_DESC_TIMEOUT_EN  When defined, a RUN that lasts TIMEOUT_CYCLES cycles
//                        without dma_done completes with status 2'b10. When
//                        undefined, RUN waits for dma_done indefinitely and
//                        there is no counter logic.
//
// Ports
//   clock, reset            clock; asynchronous active-high reset
//   desc_valid/desc_ready   descriptor push handshake
//   desc_*                  descriptor fields (addresses, size, 2D shape, tag)
//   flush                   drop every queued descriptor that has not been
//                           launched; the active job is left running
//   dma_start               1-cycle launch pulse to the DMA
//   dma_busy, dma_done      DMA status; dma_done is a pulse
//   dma_*                   registered DMA config, stable from launch through
//                           completion
//   active                  sequencer is not idle
//   queue_count             number of queued descriptors
//   cmpl_valid/tag/status   1-cycle completion record
//                           status: 00 ok, 01 bad descriptor, 10 timeout
//   dbg_state               sequencer state, for debug and checkers
//
// Handshake: a descriptor transfers on a rising clock edge where desc_valid
// and desc_ready are both high. desc_valid does not depend on desc_ready.
// desc_ready is low while flush is high or while the queue is full.
// ---------------------------------------------------------------------------
module dma_desc_queue #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  // descriptor push
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [31:0]                desc_src_addr,
  input  logic [31:0]                desc_dst_addr,
  input  logic [15:0]                desc_transfer_size,
  input  logic                       desc_mode_2d,
  input  logic [15:0]                desc_row_count,
  input  logic [15:0]                desc_col_count,
  input  logic [15:0]                desc_src_stride,
  input  logic [15:0]                desc_dst_stride,
  input  logic [7:0]                 desc_tag,
  input  logic                       flush,
  // DMA controller side
  output logic                       dma_start,
  input  logic                       dma_busy,
  input  logic                       dma_done,
  output logic [31:0]                dma_src_base_addr,
  output logic [31:0]                dma_dst_base_addr,
  output logic [15:0]                dma_transfer_size,
  output logic [15:0]                dma_row_count,
  output logic [15:0]                dma_col_count,
  output logic [15:0]                dma_src_row_stride,
  output logic [15:0]                dma_dst_row_stride,
  output logic                       dma_mode_2d,
  // status and completion
  output logic                       active,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       cmpl_valid,
  output logic [7:0]                 cmpl_tag,
  output logic [1:0]                 cmpl_status,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  localparam logic [1:0] STATUS_OK  = 2'b00;
  localparam logic [1:0] STATUS_BAD = 2'b01;

  // Bad parameter values are caught at elaboration time rather than
  // producing a queue with the wrong wrap behaviour.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dma_desc_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] size;
    logic        mode_2d;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [15:0] src_stride;
    logic [15:0] dst_stride;
    logic [7:0]  tag;
  } desc_t;

  // A linear transfer must be a non-zero whole number of 8-byte beats.
  // A 2D transfer must have at least one row and one beat per row.
  function automatic logic desc_is_bad(input desc_t d);
    if (d.mode_2d) begin
      return (d.rows == 16'd0) || (d.cols == 16'd0);
    end
    return (d.size == 16'd0) || (d.size[2:0] != 3'd0);
  endfunction

  // -------------------------------------------------------------------------
  // Descriptor FIFO
  // -------------------------------------------------------------------------
  desc_t            mem_q [DEPTH];
  desc_t            desc_in;
  desc_t            head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  always_comb begin
    desc_in            = '0;
    desc_in.src        = desc_src_addr;
    desc_in.dst        = desc_dst_addr;
    desc_in.size       = desc_transfer_size;
    desc_in.mode_2d    = desc_mode_2d;
    desc_in.rows       = desc_row_count;
    desc_in.cols       = desc_col_count;
    desc_in.src_stride = desc_src_stride;
    desc_in.dst_stride = desc_dst_stride;
    desc_in.tag        = desc_tag;
  end

  assign desc_ready = !flush && (count_q < CNT_W'(DEPTH));
  assign push       = desc_valid && desc_ready;
  assign head       = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits wide, so an increment wraps modulo
  // DEPTH. Flush cannot coincide with a push or a pop, because desc_ready and
  // the pop condition both require flush to be low.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The storage has no reset. An entry is only read after it has been
  // written, because count_q gates every pop.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= desc_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Launch sequencer
  // -------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  desc_t      cfg_q, cfg_d;
  logic [1:0] status_q, status_d;

`ifdef DMA_DESC_TIMEOUT_EN
  localparam int               TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST       = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       STATUS_TIMEOUT = 2'b10;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // LAUNCH always precedes RUN, so the counter is zero in the first RUN
  // cycle. It then counts the RUN cycles that have already elapsed.
  assign tmo_cnt_d = (state_q == ST_RUN) ? tmo_cnt_q + TMO_W'(1) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    status_d = status_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Waiting for !dma_busy also covers a DMA that is still draining a
        // job that timed out.
        if ((count_q != '0) && !dma_busy && !flush) begin
          pop   = 1'b1;
          cfg_d = head;
          if (desc_is_bad(head)) begin
            state_d  = ST_COMPLETE;
            status_d = STATUS_BAD;
          end else begin
            state_d  = ST_LAUNCH;
            status_d = STATUS_OK;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dma_done) begin
          state_d  = ST_COMPLETE;
          status_d = STATUS_OK;
        end
`ifdef DMA_DESC_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d  = ST_COMPLETE;
          status_d = STATUS_TIMEOUT;
        end
`endif
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      status_q <= STATUS_OK;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      status_q <= status_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Strobes are decoded directly from the state register. Each one is
  // therefore high for exactly the single cycle spent in its state.
  assign dma_start  = (state_q == ST_LAUNCH);
  assign cmpl_valid = (state_q == ST_COMPLETE);
  assign active     = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  assign dma_src_base_addr  = cfg_q.src;
  assign dma_dst_base_addr  = cfg_q.dst;
  assign dma_transfer_size  = cfg_q.size;
  assign dma_row_count      = cfg_q.rows;
  assign dma_col_count      = cfg_q.cols;
  assign dma_src_row_stride = cfg_q.src_stride;
  assign dma_dst_row_stride = cfg_q.dst_stride;
  assign dma_mode_2d        = cfg_q.mode_2d;

  assign queue_count = count_q;
  assign cmpl_tag    = cfg_q.tag;
  assign cmpl_status = status_q;

endmodule

// File: tb/tb_dma_desc_queue.sv
// ---------------------------------------------------------------------------
// tb_dma_desc_queue
//
// Directed bench for dma_desc_queue. The bench keeps a transaction-level
// model: a descriptor queue plus the job in flight, advanced by the
// sequencing rules. The model predicts the strobes, the queue occupancy, the
// config bus and the completion records. A compare process checks the DUT
// against the model on every negative clock edge. Each scenario then pins
// the model with literal expectations computed by hand: tags, status codes
// and cycle distances.
//
// Define DMA_DESC_TIMEOUT_EN to exercise the watchdog with
// TIMEOUT_CYCLES = 16.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dma_desc_queue;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_CMPL  = 3;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] size;
    logic        mode;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [15:0] sstr;
    logic [15:0] dstr;
    logic [7:0]  tag;
  } desc_t;

  // ---------------- clock / reset and DUT ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          desc_valid = 1'b0;
  logic          flush = 1'b0;
  logic          dma_done = 1'b0;
  logic          dma_busy;
  desc_t         in_desc = '0;
  logic          desc_ready, dma_start, dma_mode_2d, active, cmpl_valid;
  logic [31:0]   dma_src_base_addr, dma_dst_base_addr;
  logic [15:0]   dma_transfer_size, dma_row_count, dma_col_count;
  logic [15:0]   dma_src_row_stride, dma_dst_row_stride;
  logic [CW-1:0] queue_count;
  logic [7:0]    cmpl_tag;
  logic [1:0]    cmpl_status, dbg_state;

  always #5 clock = ~clock;

  dma_desc_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(in_desc.src), .desc_dst_addr(in_desc.dst),
    .desc_transfer_size(in_desc.size), .desc_mode_2d(in_desc.mode),
    .desc_row_count(in_desc.rows), .desc_col_count(in_desc.cols),
    .desc_src_stride(in_desc.sstr), .desc_dst_stride(in_desc.dstr),
    .desc_tag(in_desc.tag), .flush(flush),
    .dma_start(dma_start), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_src_base_addr(dma_src_base_addr), .dma_dst_base_addr(dma_dst_base_addr),
    .dma_transfer_size(dma_transfer_size), .dma_row_count(dma_row_count),
    .dma_col_count(dma_col_count), .dma_src_row_stride(dma_src_row_stride),
    .dma_dst_row_stride(dma_dst_row_stride), .dma_mode_2d(dma_mode_2d),
    .active(active), .queue_count(queue_count),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_status(cmpl_status),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  desc_t      m_q[$];
  desc_t      m_cur = '0;
  int         m_phase = PH_IDLE;
  int         m_run = 0;
  bit         m_take;
  logic [9:0] exp_q[$];   // expected completions: {tag, status}

  function automatic bit is_bad(input desc_t d);
    if (d.mode) return (d.rows == 0) || (d.cols == 0);
    return (d.size == 0) || ((d.size % 8) != 0);
  endfunction

  initial begin : model
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_q.delete();
        exp_q.delete();
        m_phase = PH_IDLE;
        m_cur   = '0;
        m_run   = 0;
      end else begin
        m_take = desc_valid && !flush && (m_q.size() < DEPTH);
        case (m_phase)
          PH_IDLE: begin
            if (m_q.size() > 0 && !dma_busy && !flush) begin
              m_cur = m_q.pop_front();
              if (is_bad(m_cur)) begin
                m_phase = PH_CMPL;
                exp_q.push_back({m_cur.tag, 2'b01});
              end else begin
                m_phase = PH_START;
              end
            end
          end
          PH_START: begin
            m_phase = PH_WAIT;
            m_run   = 0;
          end
          PH_WAIT: begin
            if (dma_done) begin
              m_phase = PH_CMPL;
              exp_q.push_back({m_cur.tag, 2'b00});
            end
`ifdef DMA_DESC_TIMEOUT_EN
            else begin
              m_run++;
              if (m_run == TMO) begin
                m_phase = PH_CMPL;
                exp_q.push_back({m_cur.tag, 2'b10});
              end
            end
`endif
          end
          default: m_phase = PH_IDLE;
        endcase
        if (flush) m_q.delete();
        if (m_take) m_q.push_back(in_desc);
      end
    end
  end

  // ---------------- compare process and logs ----------------
  int         start_log[$];
  int         cmpl_cycs[$];
  logic [7:0] cmpl_tags[$];
  logic [1:0] cmpl_stats[$];
  bit         start_seen = 1'b0;
  logic [9:0] exp_c;

  initial begin : compare
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("dma_start", dma_start, m_phase == PH_START);
        check("cmpl_valid", cmpl_valid, m_phase == PH_CMPL);
        check("active", active, m_phase != PH_IDLE);
        check("queue_count", queue_count, m_q.size());
        check("desc_ready", desc_ready, !flush && (m_q.size() < DEPTH));
        if (m_phase != PH_IDLE) begin
          check("cfg_src", dma_src_base_addr, m_cur.src);
          check("cfg_dst", dma_dst_base_addr, m_cur.dst);
          check("cfg_size", dma_transfer_size, m_cur.size);
          check("cfg_rows", dma_row_count, m_cur.rows);
          check("cfg_cols", dma_col_count, m_cur.cols);
          check("cfg_sstride", dma_src_row_stride, m_cur.sstr);
          check("cfg_dstride", dma_dst_row_stride, m_cur.dstr);
          check("cfg_mode", dma_mode_2d, m_cur.mode);
        end
        if (dma_start) begin
          start_seen = 1'b1;
          start_log.push_back(cyc);
        end
        if (cmpl_valid) begin
          cmpl_cycs.push_back(cyc);
          cmpl_tags.push_back(cmpl_tag);
          cmpl_stats.push_back(cmpl_status);
          if (exp_q.size() == 0) begin
            check("cmpl_unexpected", {cmpl_tag, cmpl_status}, 10'h3ff);
          end else begin
            exp_c = exp_q.pop_front();
            check("cmpl_record", {cmpl_tag, cmpl_status}, exp_c);
          end
        end
      end
    end
  end

  // ---------------- DMA responder ----------------
  int   done_delay = 10;
  int   rem = 0;
  bit   pend = 1'b0;
  bit   no_done = 1'b0;
  bit   force_done = 1'b0;
  logic resp_busy = 1'b0;
  logic busy_hold = 1'b0;

  assign dma_busy = resp_busy || busy_hold;

  // dma_done arrives done_delay cycles after the dma_start cycle.
  initial begin : responder
    forever begin
      @(posedge clock);
      #1;
      dma_done = 1'b0;
      if (force_done) begin
        force_done = 1'b0;
        dma_done   = 1'b1;
      end
      if (start_seen) begin
        start_seen = 1'b0;
        if (!no_done) begin
          pend      = 1'b1;
          rem       = done_delay - 1;
          resp_busy = 1'b1;
        end
      end else if (pend) begin
        rem--;
      end
      if (pend && rem == 0) begin
        dma_done  = 1'b1;
        pend      = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic desc_t mk(input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] size, input logic mode,
                               input logic [15:0] rows, input logic [15:0] cols,
                               input logic [15:0] sstr, input logic [15:0] dstr,
                               input logic [7:0] tag);
    desc_t d;
    d.src = src; d.dst = dst; d.size = size; d.mode = mode; d.rows = rows;
    d.cols = cols; d.sstr = sstr; d.dstr = dstr; d.tag = tag;
    return d;
  endfunction

  // Called just after a rising edge. Returns just after the accepting edge.
  task automatic push(input desc_t d);
    int n;
    n = 0;
    in_desc    = d;
    desc_valid = 1'b1;
    @(negedge clock);
    while (!desc_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!desc_ready) check("push_timeout", 1'b0, 1'b1);
    @(posedge clock);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((m_phase != PH_IDLE || m_q.size() != 0 || pend) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_drain_timeout"}, n < budget, 1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    start_log.delete();
    cmpl_cycs.delete();
    cmpl_tags.delete();
    cmpl_stats.delete();
  endtask

  int acc;

  // ---------------- directed scenarios ----------------
  initial begin : main
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready", desc_ready, 1'b1);
    check("rst_start", dma_start, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_count", queue_count, 0);
    check("rst_cmpl", cmpl_valid, 1'b0);
    check("rst_src", dma_src_base_addr, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // One linear descriptor, size 64, tag 0x11, done 10 cycles after start
    clear_logs();
    done_delay = 10;
    push(mk(32'h1000_0000, 32'h2000_0040, 16'd64, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h11));
    acc = cyc;
    wait_drain("t1", 100);
    check("t1_starts", start_log.size(), 1);
    check("t1_cmpls", cmpl_tags.size(), 1);
    if (start_log.size() == 1 && cmpl_tags.size() == 1) begin
      check("t1_start_latency", start_log[0] - acc, 1);
      check("t1_done_to_cmpl", cmpl_cycs[0] - start_log[0], 11);
      check("t1_tag", cmpl_tags[0], 8'h11);
      check("t1_status", cmpl_stats[0], 2'b00);
    end
    check("t1_cfg_src", dma_src_base_addr, 32'h1000_0000);
    check("t1_cfg_dst", dma_dst_base_addr, 32'h2000_0040);
    check("t1_cfg_size", dma_transfer_size, 16'd64);
    check("t1_cfg_mode", dma_mode_2d, 1'b0);

    // A good 2D descriptor
    clear_logs();
    done_delay = 3;
    push(mk(32'h3000_0000, 32'h4000_0000, 16'd0, 1'b1, 16'd4, 16'd8, 16'h100, 16'h200, 8'h22));
    wait_drain("t1b", 100);
    check("t1b_starts", start_log.size(), 1);
    check("t1b_cmpls", cmpl_tags.size(), 1);
    if (start_log.size() == 1 && cmpl_tags.size() == 1) begin
      check("t1b_tag", cmpl_tags[0], 8'h22);
      check("t1b_status", cmpl_stats[0], 2'b00);
      check("t1b_done_to_cmpl", cmpl_cycs[0] - start_log[0], 4);
    end
    check("t1b_rows", dma_row_count, 16'd4);
    check("t1b_cols", dma_col_count, 16'd8);
    check("t1b_dstride", dma_dst_row_stride, 16'h200);
    check("t1b_mode", dma_mode_2d, 1'b1);

    // Fill the queue while the DMA reports busy, then drain it in order
    clear_logs();
    busy_hold  = 1'b1;
    done_delay = 2;
    for (int i = 0; i < 4; i++) begin
      push(mk(32'h100 * i, 32'h8000 + 32'h100 * i, 16'(8 * (i + 1)), 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'(i)));
    end
    @(negedge clock);
    check("t2_full_ready", desc_ready, 1'b0);
    check("t2_full_count", queue_count, 4);
    // A push attempt while full must not be accepted
    in_desc    = mk(32'hdead, 32'hbeef, 16'd8, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h99);
    desc_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    desc_valid = 1'b0;
    check("t2_still_full", queue_count, 4);
    busy_hold = 1'b0;
    wait_drain("t2", 200);
    check("t2_starts", start_log.size(), 4);
    check("t2_cmpls", cmpl_tags.size(), 4);
    if (cmpl_tags.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_tag_order", cmpl_tags[i], 8'(i));
        check("t2_status", cmpl_stats[i], 2'b00);
      end
    end
    if (start_log.size() == 4) begin
      check("t2_start_spacing", start_log[1] - start_log[0], 5);
    end

    // Two bad descriptors: linear size 12, and 2D with zero rows
    clear_logs();
    push(mk(32'h500, 32'h600, 16'd12, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h31));
    push(mk(32'h700, 32'h800, 16'd64, 1'b1, 16'd0, 16'd5, 16'd0, 16'd0, 8'h32));
    wait_drain("t3", 100);
    check("t3_starts", start_log.size(), 0);
    check("t3_cmpls", cmpl_tags.size(), 2);
    if (cmpl_tags.size() == 2) begin
      check("t3_tag0", cmpl_tags[0], 8'h31);
      check("t3_status0", cmpl_stats[0], 2'b01);
      check("t3_tag1", cmpl_tags[1], 8'h32);
      check("t3_status1", cmpl_stats[1], 2'b01);
    end

    // Flush with three queued and one running
    clear_logs();
    done_delay = 30;
    for (int i = 0; i < 4; i++) begin
      push(mk(32'h9000 + 32'(i), 32'ha000, 16'd16, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h40 + 8'(i)));
    end
    @(negedge clock);
    check("t4_count_before", queue_count, 3);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(negedge clock);
    check("t4_ready_in_flush", desc_ready, 1'b0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("t4_count_after", queue_count, 0);
    wait_drain("t4", 200);
    check("t4_starts", start_log.size(), 1);
    check("t4_cmpls", cmpl_tags.size(), 1);
    if (cmpl_tags.size() == 1) begin
      check("t4_tag", cmpl_tags[0], 8'h40);
      check("t4_status", cmpl_stats[0], 2'b00);
    end

    // Reset during RUN, with one more descriptor queued
    clear_logs();
    done_delay = 20;
    push(mk(32'hb000, 32'hc000, 16'd32, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h50));
    push(mk(32'hb100, 32'hc100, 16'd32, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h51));
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("t5_rst_start", dma_start, 1'b0);
    check("t5_rst_active", active, 1'b0);
    check("t5_rst_cmpl", cmpl_valid, 1'b0);
    check("t5_rst_count", queue_count, 0);
    check("t5_rst_ready", desc_ready, 1'b1);
    check("t5_rst_src", dma_src_base_addr, 32'h0);
    check("t5_rst_size", dma_transfer_size, 16'h0);
    check("t5_rst_tag", cmpl_tag, 8'h0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    wait_drain("t5", 100);
    check("t5_starts", start_log.size(), 1);
    check("t5_no_cmpl", cmpl_tags.size(), 0);

    // DMA never signals done
    clear_logs();
    no_done = 1'b1;
    push(mk(32'hd000, 32'he000, 16'd16, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h60));
`ifdef DMA_DESC_TIMEOUT_EN
    wait_drain("t6", 100);
    check("t6_cmpls", cmpl_tags.size(), 1);
    if (cmpl_tags.size() == 1 && start_log.size() == 1) begin
      check("t6_tag", cmpl_tags[0], 8'h60);
      check("t6_status", cmpl_stats[0], 2'b10);
      check("t6_timeout_latency", cmpl_cycs[0] - start_log[0], 17);
    end
    force_done = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("t6_stray_done_ignored", cmpl_tags.size(), 1);
`else
    repeat (40) @(posedge clock);
    #1;
    check("t6_still_active", active, 1'b1);
    check("t6_no_cmpl", cmpl_tags.size(), 0);
    force_done = 1'b1;
    wait_drain("t6", 100);
    check("t6_cmpls", cmpl_tags.size(), 1);
    if (cmpl_tags.size() == 1) begin
      check("t6_tag", cmpl_tags[0], 8'h60);
      check("t6_status", cmpl_stats[0], 2'b00);
    end
`endif
    no_done = 1'b0;

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
